// File: rtl/cva6_region_cfg_regs.sv
// cva6_region_cfg_regs
//   Runtime-programmable region rule table (cached / non-idempotent / exec).
//   Each of NrRules rules has a staged copy (written over the cfg port) and an
//   active copy (used by lookups). A commit swaps every staged rule into the
//   active table on a single edge. The swap waits for a cycle with no lookups,
//   or is forced once it has waited MaxDefer cycles.
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_req_i/we/idx/wdata register access; cfg_gnt_o = cfg_req_i
//   cfg_rvalid_o/rdata/err response one cycle after the request
//   lkp_valid_i/addr_i    per-channel lookup request
//   lkp_valid_o/hit/attr  registered lookup result, attr = {exec,nonidem,cached}
//   commit_busy_o         a commit is waiting for its swap
module cva6_region_cfg_regs #(
    parameter int unsigned NrRules    = 4,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned NrChannels = 2,
    parameter int unsigned MaxDefer   = 15,
    parameter int unsigned RegIdxW    = $clog2(2 + 3 * NrRules)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   cfg_req_i,
    input  logic                                   cfg_we_i,
    input  logic [RegIdxW-1:0]                     cfg_idx_i,
    input  logic [63:0]                            cfg_wdata_i,
    output logic                                   cfg_gnt_o,
    output logic                                   cfg_rvalid_o,
    output logic [63:0]                            cfg_rdata_o,
    output logic                                   cfg_err_o,
    input  logic [NrChannels-1:0]                  lkp_valid_i,
    input  logic [NrChannels-1:0][AddrWidth-1:0]   lkp_addr_i,
    output logic [NrChannels-1:0]                  lkp_valid_o,
    output logic [NrChannels-1:0]                  lkp_hit_o,
    output logic [NrChannels-1:0][2:0]             lkp_attr_o,
    output logic                                   commit_busy_o
);

    localparam int unsigned NrRegs = 2 + 3 * NrRules;
    localparam int unsigned STAGES = 1;
    localparam int unsigned CntW   = 8;

    typedef enum logic {IDLE, PENDING} state_e;

    state_e                              state_q;
    logic [CntW-1:0]                     cnt_q;
    logic                                lock_q;
    logic [NrRules-1:0][AddrWidth-1:0]   stg_base, stg_len, act_base, act_len;
    logic [NrRules-1:0][2:0]             stg_attr, act_attr;
    logic [NrRules-1:0][AddrWidth-1:0]   stg_base_d, stg_len_d;
    logic [NrRules-1:0][2:0]             stg_attr_d;
    logic [NrRules-1:0][AddrWidth:0]     act_end;
    logic [STAGES-1:0][NrChannels-1:0]   vld_pipe;
    logic [NrChannels-1:0]               hit_d;
    logic [NrChannels-1:0][2:0]          attr_d;
    logic [63:0]                         rdata_d;
    logic                                err_d, commit_fire, lock_set, swap, any_lkp;
    logic [31:0]                         idx32;

    assign cfg_gnt_o     = cfg_req_i;
    assign commit_busy_o = (state_q == PENDING);
    assign lkp_valid_o   = vld_pipe[STAGES-1];
    assign idx32         = 32'(cfg_idx_i);
    assign any_lkp       = |lkp_valid_i;

    // Register decode. stg_*_d is the staged table with this cycle's write
    // applied, so a swap on the same edge picks the write up.
    always_comb begin
        stg_base_d  = stg_base;
        stg_len_d   = stg_len;
        stg_attr_d  = stg_attr;
        rdata_d     = '0;
        err_d       = 1'b0;
        commit_fire = 1'b0;
        lock_set    = 1'b0;
        if (cfg_req_i) begin
            if (idx32 >= NrRegs) begin
                err_d = 1'b1;
            end else if (idx32 == 0) begin
                if (cfg_we_i) begin
                    // Commit is evaluated against the old lock, so commit+lock
                    // together commits first and then locks.
                    if (lock_q) err_d = cfg_wdata_i[0];
                    else        commit_fire = cfg_wdata_i[0];
                    lock_set = cfg_wdata_i[1];
                end else begin
                    rdata_d = {62'b0, lock_q, 1'b0};
                end
            end else if (idx32 == 1) begin
                if (cfg_we_i) err_d = 1'b1;
                else rdata_d = 64'({cnt_q, 6'b0, lock_q, state_q == PENDING});
            end else begin
                for (int unsigned r = 0; r < NrRules; r++) begin
                    if (idx32 == 2 + 3 * r) begin
                        if (!cfg_we_i)   rdata_d = 64'(stg_base[r]);
                        else if (lock_q) err_d = 1'b1;
                        else             stg_base_d[r] = AddrWidth'(cfg_wdata_i);
                    end else if (idx32 == 3 + 3 * r) begin
                        if (!cfg_we_i)   rdata_d = 64'(stg_len[r]);
                        else if (lock_q) err_d = 1'b1;
                        else             stg_len_d[r] = AddrWidth'(cfg_wdata_i);
                    end else if (idx32 == 4 + 3 * r) begin
                        if (!cfg_we_i)   rdata_d = {61'b0, stg_attr[r]};
                        else if (lock_q) err_d = 1'b1;
                        else             stg_attr_d[r] = cfg_wdata_i[2:0];
                    end
                end
            end
        end
    end

    // Swap decision: immediate when idle lookups, else deferred up to MaxDefer.
    always_comb begin
        swap = 1'b0;
        case (state_q)
            IDLE:    swap = commit_fire && !any_lkp;
            PENDING: swap = !any_lkp || (cnt_q == CntW'(MaxDefer - 1));
            default: swap = 1'b0;
        endcase
    end

    // Lookup match against the active table. End bound is one bit wider so a
    // rule reaching the top of the address space never wraps.
    always_comb begin
        hit_d  = '0;
        attr_d = '0;
        for (int unsigned r = 0; r < NrRules; r++)
            act_end[r] = {1'b0, act_base[r]} + {1'b0, act_len[r]};
        for (int unsigned c = 0; c < NrChannels; c++) begin
            if (lkp_valid_i[c]) begin
                for (int unsigned r = 0; r < NrRules; r++) begin
                    if ((act_len[r] != '0) && (lkp_addr_i[c] >= act_base[r]) &&
                        ({1'b0, lkp_addr_i[c]} < act_end[r])) begin
                        hit_d[c]  = 1'b1;
                        attr_d[c] = attr_d[c] | act_attr[r];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lock_q       <= 1'b0;
            stg_base     <= '0;
            stg_len      <= '0;
            stg_attr     <= '0;
            act_base     <= '0;
            act_len      <= '0;
            act_attr     <= '0;
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
            cfg_err_o    <= 1'b0;
            vld_pipe     <= '0;
            lkp_hit_o    <= '0;
            lkp_attr_o   <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_rdata_o  <= rdata_d;
            cfg_err_o    <= err_d;
            stg_base     <= stg_base_d;
            stg_len      <= stg_len_d;
            stg_attr     <= stg_attr_d;
            if (lock_set) lock_q <= 1'b1;
            if (swap) begin
                act_base <= stg_base_d;
                act_len  <= stg_len_d;
                act_attr <= stg_attr_d;
            end
            case (state_q)
                IDLE: begin
                    if (commit_fire && any_lkp) begin
                        state_q <= PENDING;
                        cnt_q   <= '0;
                    end
                end
                PENDING: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (swap) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            vld_pipe[0] <= lkp_valid_i;
            for (int unsigned s = 1; s < STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
            lkp_hit_o  <= hit_d;
            lkp_attr_o <= attr_d;
        end
    end

endmodule
